fm_modulate: RTL and testbench

FM_MODULATE -- requirements
Module: fm_modulate

---
 rtl/fm_modulate_if.sv | 42 ++++
 rtl/fm_modulate.sv | 168 ++++++++++++++++
 tb/tb_fm_modulate.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fm_modulate_if.sv
// FM modulator streaming bus: FWFT audio input FIFO pop side, real/imag output FIFO push sides.
// Latency: none, signal bundle only.
// Backpressure: in_empty gates pops; real_full/imag_full gate the paired pushes.
interface fm_modulate_if #(
  parameter int DATA_SIZE = 32
);
  logic                 in_rd_en;
  logic                 in_empty;
  logic [DATA_SIZE-1:0] in_din;
  logic [DATA_SIZE-1:0] real_out;
  logic                 real_wr_en;
  logic                 real_full;
  logic [DATA_SIZE-1:0] imag_out;
  logic                 imag_wr_en;
  logic                 imag_full;

  // Modulator side
  modport master (
    output in_rd_en,
    input  in_empty,
    input  in_din,
    output real_out,
    output real_wr_en,
    input  real_full,
    output imag_out,
    output imag_wr_en,
    input  imag_full
  );

  // FIFO / environment side
  modport slave (
    input  in_rd_en,
    output in_empty,
    output in_din,
    input  real_out,
    input  real_wr_en,
    output real_full,
    input  imag_out,
    input  imag_wr_en,
    output imag_full
  );
endinterface

// File: rtl/fm_modulate.sv
// FM modulator: phase += dequant(sample*gain), wrap to [-pi,pi), CORDIC cos/sin -> Q10 I/Q pair.
// Latency: 18+k cycles from in_rd_en to the write pair (k = wrap corrections); one sample per 19 cycles peak.
// Backpressure: holds in WRITE with both write enables low while either output FIFO is full.
module fm_modulate #(
  parameter int DATA_SIZE   = 32,
  parameter int BITS        = 10,
  parameter int MOD_GAIN    = 32'h00000567,
  parameter int CORDIC_ITER = 14
) (
  input  logic          clock,
  input  logic          reset,
  fm_modulate_if.master bus
);

  typedef enum logic [2:0] {IDLE, SCALE, WRAP, PREROT, CORDIC, WRITE} state_t;

  localparam logic signed [DATA_SIZE-1:0] GAIN          = DATA_SIZE'(MOD_GAIN);
  localparam logic signed [DATA_SIZE-1:0] PI_Q          = DATA_SIZE'(3217);
  localparam logic signed [DATA_SIZE-1:0] NEG_PI_Q      = -PI_Q;
  localparam logic signed [DATA_SIZE-1:0] TWO_PI_Q      = DATA_SIZE'(6434);
  localparam logic signed [DATA_SIZE-1:0] HALF_PI_Q     = DATA_SIZE'(1608);
  localparam logic signed [DATA_SIZE-1:0] NEG_HALF_PI_Q = -HALF_PI_Q;
  localparam logic signed [DATA_SIZE-1:0] CORDIC_K      = DATA_SIZE'(9949);
  localparam logic [3:0]                  LAST_ITER     = 4'(CORDIC_ITER - 1);

  // round(atan(2^-i) * 2^14)
  localparam int ATAN_LUT [16] = '{12868, 7596, 4014, 2037, 1023, 512, 256, 128,
                                   64, 32, 16, 8, 4, 2, 1, 0};

  state_t state, next_state;

  logic signed [DATA_SIZE-1:0] din_q;
  logic signed [DATA_SIZE-1:0] phase;
  logic signed [DATA_SIZE-1:0] x, y, z;
  logic                        neg;
  logic [3:0]                  iter;
  logic signed [DATA_SIZE-1:0] real_q, imag_q;

  logic                        rd_en, wr_en;
  logic signed [DATA_SIZE-1:0] prod_lo, delta;
  logic                        wrap_hi, wrap_lo;
  logic signed [DATA_SIZE-1:0] angle;
  logic                        pre_neg;
  logic signed [DATA_SIZE-1:0] atan_i, x_nx, y_nx, z_nx, re_fin, im_fin;
  logic                        last_iter;

  // Only the low DATA_SIZE bits of the product are kept, so a same-width multiply suffices.
  assign prod_lo = din_q * GAIN;
  // Dequantise rounding toward zero: negative values are shifted as magnitudes.
  assign delta   = prod_lo[DATA_SIZE-1] ? -((-prod_lo) >>> BITS) : (prod_lo >>> BITS);

  assign wrap_hi = (phase >= PI_Q);
  assign wrap_lo = (phase < NEG_PI_Q);

  // Fold the phase into [-pi/2, pi/2] for CORDIC convergence; the half-turn is restored by negation.
  always_comb begin
    angle   = phase;
    pre_neg = 1'b0;
    if (phase > HALF_PI_Q) begin
      angle   = phase - PI_Q;
      pre_neg = 1'b1;
    end else if (phase < NEG_HALF_PI_Q) begin
      angle   = phase + PI_Q;
      pre_neg = 1'b1;
    end
  end

  // One rotation-mode CORDIC step; direction follows the sign of the residual angle.
  always_comb begin
    atan_i = DATA_SIZE'(ATAN_LUT[iter]);
    if (!z[DATA_SIZE-1]) begin
      x_nx = x - (y >>> iter);
      y_nx = y + (x >>> iter);
      z_nx = z - atan_i;
    end else begin
      x_nx = x + (y >>> iter);
      y_nx = y - (x >>> iter);
      z_nx = z + atan_i;
    end
    re_fin = neg ? -(x_nx >>> 4) : (x_nx >>> 4);
    im_fin = neg ? -(y_nx >>> 4) : (y_nx >>> 4);
  end

  assign last_iter = (iter == LAST_ITER);

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // FSM next state and handshake strobes
  always_comb begin
    next_state = state;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.in_empty) begin
          rd_en      = 1'b1;
          next_state = SCALE;
        end
      end
      SCALE:  next_state = WRAP;
      WRAP:   if (!wrap_hi && !wrap_lo) next_state = PREROT;
      PREROT: next_state = CORDIC;
      CORDIC: if (last_iter) next_state = WRITE;
      WRITE: begin
        if (!bus.real_full && !bus.imag_full) begin
          wr_en      = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers, advanced according to the current state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      din_q  <= '0;
      phase  <= '0;
      x      <= '0;
      y      <= '0;
      z      <= '0;
      neg    <= 1'b0;
      iter   <= '0;
      real_q <= '0;
      imag_q <= '0;
    end else begin
      case (state)
        IDLE:   if (!bus.in_empty) din_q <= $signed(bus.in_din);
        SCALE:  phase <= phase + delta;
        WRAP: begin
          if (wrap_hi)      phase <= phase - TWO_PI_Q;
          else if (wrap_lo) phase <= phase + TWO_PI_Q;
        end
        PREROT: begin
          x    <= CORDIC_K;
          y    <= '0;
          z    <= angle <<< 4;
          neg  <= pre_neg;
          iter <= '0;
        end
        CORDIC: begin
          x    <= x_nx;
          y    <= y_nx;
          z    <= z_nx;
          iter <= iter + 4'd1;
          if (last_iter) begin
            real_q <= re_fin;
            imag_q <= im_fin;
          end
        end
        default: ;
      endcase
    end
  end

  // The pop strobe is decoded from IDLE, which is also the reset state, so it is
  // masked by reset to keep the input FIFO untouched while reset is held.
  assign bus.in_rd_en   = rd_en & reset;
  assign bus.real_wr_en = wr_en;
  assign bus.imag_wr_en = wr_en;
  assign bus.real_out   = real_q;
  assign bus.imag_out   = imag_q;

endmodule

// File: tb/tb_fm_modulate.sv
// Testbench for fm_modulate: table-driven sample stream plus backpressure and mid-operation reset sequences.
module tb_fm_modulate;

  logic clock;
  logic reset;

  fm_modulate_if #(.DATA_SIZE(32)) bus ();

  fm_modulate #(
    .DATA_SIZE  (32),
    .BITS       (10),
    .MOD_GAIN   (1024),
    .CORDIC_ITER(14)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    int din;
    int re;
    int im;
    int k;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  int fq[$];
  int rd_q[$];
  int wr_q[$];
  int re_q[$];
  int im_q[$];
  int both_q[$];
  int cyc;
  int n_cmp;
  int n_bad;

  task automatic check(input string name, input int act, input int exp, input int tol);
    n_cmp++;
    if (act > exp + tol || act < exp - tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic drive_fifo();
    bus.in_empty = (fq.size() == 0);
    bus.in_din   = (fq.size() != 0) ? fq[0] : 0;
  endtask

  // One clock cycle: observe strobes on the falling edge, pop after the rising edge.
  task automatic step();
    logic rd;
    @(negedge clock);
    cyc++;
    rd = bus.in_rd_en;
    if (rd) rd_q.push_back(cyc);
    if (bus.real_wr_en || bus.imag_wr_en) begin
      wr_q.push_back(cyc);
      re_q.push_back(int'($signed(bus.real_out)));
      im_q.push_back(int'($signed(bus.imag_out)));
      both_q.push_back((bus.real_wr_en && bus.imag_wr_en) ? 1 : 0);
    end
    @(posedge clock);
    #1;
    if (rd && fq.size() > 0) void'(fq.pop_front());
    drive_fifo();
  endtask

  initial begin
    int r0, w0, w1, bp_cyc;

    // din, expected real, expected imag, wrap corrections (gain = 1.0, phase accumulates)
    tbl[0]  = '{0,      1024,  0,    0};
    tbl[1]  = '{0,      1024,  0,    0};
    tbl[2]  = '{0,      1024,  0,    0};
    tbl[3]  = '{804,    724,   724,  0};
    tbl[4]  = '{804,    0,     1024, 0};
    tbl[5]  = '{804,   -724,   725,  0};
    tbl[6]  = '{804,   -1024,  1,    0};
    tbl[7]  = '{804,   -725,  -723,  1};
    tbl[8]  = '{-804,  -1024,  1,    1};
    tbl[9]  = '{-3216,  1024,  0,    0};
    tbl[10] = '{10000, -965,  -342,  2};
    tbl[11] = '{-10000, 1024,  0,    2};
    tbl[12] = '{-1000,  573,  -848,  0};
    tbl[13] = '{-1000, -382,  -950,  0};

    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    bus.real_full = 1'b0;
    bus.imag_full = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < NV; i++) fq.push_back(tbl[i].din);
    drive_fifo();
    #1 reset = 1'b0;

    // Reset held with a non-empty FIFO
    repeat (3) step();
    check("reset reads", rd_q.size(), 0, 0);
    check("reset writes", wr_q.size(), 0, 0);
    check("reset real_out", int'($signed(bus.real_out)), 0, 0);
    check("reset imag_out", int'($signed(bus.imag_out)), 0, 0);
    reset = 1'b1;
    step();
    check("first read cycle", (rd_q.size() > 0) ? rd_q[0] : -1, 4, 0);

    // Back-to-back table stream
    for (int t = 0; t < 700 && wr_q.size() < NV; t++) step();
    check("table write count", wr_q.size(), NV, 0);
    for (int i = 0; i < NV; i++) begin
      if (i < wr_q.size() && i < rd_q.size()) begin
        check($sformatf("vec%0d real", i), re_q[i], tbl[i].re, 2);
        check($sformatf("vec%0d imag", i), im_q[i], tbl[i].im, 2);
        check($sformatf("vec%0d paired", i), both_q[i], 1, 0);
        check($sformatf("vec%0d latency", i), wr_q[i] - rd_q[i], 18 + tbl[i].k, 0);
        if (i > 0)
          check($sformatf("vec%0d spacing", i), wr_q[i] - wr_q[i-1], 19 + tbl[i].k, 0);
      end
    end

    // Backpressure: real FIFO full, then imag FIFO full, while a further sample waits
    bus.real_full = 1'b1;
    r0 = rd_q.size();
    w0 = wr_q.size();
    fq.push_back(2000);
    fq.push_back(804);
    drive_fifo();
    for (int t = 0; t < 5 && rd_q.size() == r0; t++) step();
    check("bp read", rd_q.size() - r0, 1, 0);
    repeat (22) step();
    check("bp real_full writes", wr_q.size() - w0, 0, 0);
    check("bp real_full reads", rd_q.size() - r0, 1, 0);
    bus.real_full = 1'b0;
    bus.imag_full = 1'b1;
    repeat (6) step();
    check("bp imag_full writes", wr_q.size() - w0, 0, 0);
    check("bp imag_full reads", rd_q.size() - r0, 1, 0);
    bus.imag_full = 1'b0;
    step();
    bp_cyc = cyc;
    check("bp write count", wr_q.size() - w0, 1, 0);
    if (wr_q.size() > w0) begin
      check("bp write cycle", wr_q[w0], bp_cyc, 0);
      check("bp real", re_q[w0], 1024, 2);
      check("bp imag", im_q[w0], 0, 2);
      check("bp paired", both_q[w0], 1, 0);
    end
    step();
    check("bp next read count", rd_q.size() - r0, 2, 0);
    check("bp next read cycle", rd_q[rd_q.size()-1], bp_cyc + 1, 0);

    // Reset during CORDIC of the 804 sample, which has already advanced the phase
    repeat (7) step();
    reset = 1'b0;
    w1 = wr_q.size();
    r0 = rd_q.size();
    repeat (2) step();
    check("midreset real_out", int'($signed(bus.real_out)), 0, 0);
    check("midreset imag_out", int'($signed(bus.imag_out)), 0, 0);
    check("midreset writes", wr_q.size() - w1, 0, 0);
    reset = 1'b1;
    fq.push_back(0);
    drive_fifo();
    for (int t = 0; t < 40 && wr_q.size() == w1; t++) step();
    check("post-reset write count", wr_q.size() - w1, 1, 0);
    check("post-reset read count", rd_q.size() - r0, 1, 0);
    if (wr_q.size() > w1) begin
      check("post-reset real", re_q[w1], 1024, 2);
      check("post-reset imag", im_q[w1], 0, 2);
      check("post-reset paired", both_q[w1], 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
